// File: rtl/uart_tx_if.sv
// uart_tx_if: parallel byte handshake into the UART transmitter.
// Ports: tx_data/tx_valid from the master (producer), tx_ready back from the slave (uart_tx).
interface uart_tx_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART serialiser (start, LSB-first data, optional parity, 1/2 stop bits).
// Ports: clk, rst (async active-low), baud_tick (bit-period enable), bus (slave handshake),
//        tx (serial out, idle high), tx_busy (frame in progress), tx_done (last stop bit finished).
module uart_tx #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    uart_tx_if.slave   bus,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int             CW        = $clog2(DATA_BITS);
    localparam logic [CW-1:0]  LAST      = CW'(DATA_BITS - 1);
    localparam logic           STOP_LAST = (STOP_BITS == 2);
    localparam logic           PEN       = (PARITY_EN != 0);
    localparam logic           PODD      = (PARITY_ODD != 0);

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 stop_q, stop_d;
    logic                 tx_q, tx_d;
    logic                 done_q, done_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            stop_q  <= stop_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        stop_d  = stop_q;
        tx_d    = tx_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (bus.tx_valid && ready_q) begin
                    state_d = ARM;
                    shift_d = bus.tx_data;
                    // Seeding with the sense bit makes the final value the parity bit.
                    par_d   = PODD;
                    cnt_d   = '0;
                    stop_d  = 1'b0;
                end
            end
            ARM: begin
                // Wait for a fresh tick so the start bit spans a full interval.
                if (baud_tick) begin
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    par_d   = par_q ^ shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (cnt_q == LAST) begin
                        stop_d = 1'b0;
                        if (PEN) begin
                            state_d = PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        tx_d    = shift_q[0];
                        par_d   = par_q ^ shift_q[0];
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                    stop_d  = 1'b0;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (stop_q == STOP_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign bus.tx_ready = ready_q;
    assign tx           = tx_q;
    assign tx_busy      = busy_q;
    assign tx_done      = done_q;
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART serial transmitter; the stage directly downstream of baud_rate_generator.
- Serialises parallel bytes onto the tx line, LSB first, with start bit, optional parity and 1 or 2 stop bits.
- Bit timing comes only from the generator's one-clk-wide baud tick, used as an enable. The generator output is never used as a clock.
- All logic runs on the single system clock.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, parity sense when PARITY_EN=1; 0 = even, 1 = odd.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
baud_tick  input  1  one-clk strobe per bit period, from baud_rate_generator
tx_data  input  DATA_BITS  byte to send; sampled only on handshake
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a frame
tx  output  1  serial line out, idle high
tx_busy  output  1  frame in progress (not IDLE)
tx_done  output  1  one-clk pulse when the final stop bit completes

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-frame):
  - state=IDLE; tx=1, tx_ready=1, tx_busy=0, tx_done=0.
  - Shift register, bit counter and parity accumulator are cleared.
  - Any partial frame is abandoned with no tx_done.
- All outputs are registered; tx_ready = (state==IDLE).
- Handshake: a transfer occurs on the rising edge where tx_valid=1 and tx_ready=1.
  - tx_data is latched into the shift register; state goes to ARM.
  - tx_valid and tx_data outside a handshake cycle are ignored; changing them while busy has no effect.
- FSM states: IDLE, ARM, START, DATA, PARITY, STOP. Except for the handshake, every transition happens only on a clk edge with baud_tick=1.
  - IDLE: tx=1. baud_tick is ignored. Handshake -> ARM.
  - ARM: tx=1. A baud_tick in the handshake cycle itself does not count. On the next baud_tick -> START, tx<=0.
    - Purpose: the start bit lasts exactly one tick interval.
  - START: on baud_tick -> DATA, tx<=shift[0]; bit counter=0.
  - DATA: on each baud_tick, shift right and advance the counter.
    - After bit DATA_BITS-1: go to PARITY if PARITY_EN, else STOP with tx<=1.
  - PARITY: tx = XOR of all data bits, XOR PARITY_ODD. On baud_tick -> STOP, tx<=1.
  - STOP: tx=1 for STOP_BITS tick intervals.
    - On the baud_tick ending the last stop bit: -> IDLE, tx_done=1 for exactly that one clk.
- Bit period: every bit (start, data, parity, stop) lasts exactly one tick-to-tick interval.
  - Frame length = 1 + DATA_BITS + PARITY_EN + STOP_BITS ticks after the arming tick.
- Back-to-back: the earliest re-handshake is the clk after the return to IDLE.
  - The arming wait guarantees at least one extra idle-high bit period between consecutive frames.
- tx_busy = 1 in ARM/START/DATA/PARITY/STOP.
- If baud_tick stalls (stays 0), the FSM holds its state and tx holds its level indefinitely.
- The bit counter is wide enough for DATA_BITS-1 and never wraps past it.

Test Plan:
- Reset: hold rst=0 for 3 clks with tx_valid=1 -> tx=1, tx_ready=1, tx_busy=0, tx_done=0, no handshake.
- Basic 8N1: baud_tick every 4 clks, send 0xA5.
  - tx, sampled at mid-bit, reads 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses once, 40 clks after the arming tick; tx_ready returns to 1.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0xA5 -> parity bit 0. With PARITY_ODD=1 -> parity bit 1. Frame = 11 bit periods.
- Two stop bits and back-to-back: STOP_BITS=2, tx_valid held high with 0x00 then 0xFF.
  - Each frame ends with 2 high bits, followed by at least 1 idle-high bit period before the next start bit.
  - Exactly 2 tx_done pulses.
- Tick coincident with handshake: assert tx_valid so the handshake edge has baud_tick=1.
  - Start bit begins only at the following tick and lasts a full 4 clks.
- Reset mid-frame: drop rst during data bit 3 of 0x3C -> tx=1 immediately, no tx_done. After rst=1, a new frame 0x81 transmits correctly.
